mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, max consecutive data-port grants while fetch waits (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  fetch port read request.
REQ-005 if_addr  input  13  fetch word address.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rdata  output  16  fetched instruction, registered.
REQ-008 if_valid  output  1  if_rdata valid (one-cycle pulse).
REQ-009 dm_req  input  1  data port request.
REQ-010 dm_wr  input  1  data request is write (1) or read (0).
REQ-011 dm_addr  input  13  data word address.
REQ-012 dm_wdata  input  16  write data.
REQ-013 dm_gnt  output  1  data request accepted this cycle.
REQ-014 dm_rdata  output  16  load data, registered.
REQ-015 dm_valid  output  1  dm_rdata valid (one-cycle pulse, reads only).
REQ-016 mem_en  output  1  memory enable to single-port memory.
REQ-017 mem_wr  output  1  memory write strobe.
REQ-018 mem_addr  output  13  memory address.
REQ-019 mem_wdata  output  16  memory write data.
REQ-020 mem_rdata  input  16  memory read data, combinational from mem_addr same cycle.

Function
REQ-021 At most one of if_gnt/dm_gnt SHALL be 1 in any cycle; grants are combinational from current requests and registered state.
REQ-022 Only if_req: if_gnt=1; mem_en=1, mem_wr=0, mem_addr=if_addr.
REQ-023 Only dm_req: dm_gnt=1; mem_en=1, mem_wr=dm_wr, mem_addr=dm_addr, mem_wdata=dm_wdata.
REQ-024 Both requesting: dm wins unless streak counter == STARVE_LIMIT, then fetch wins.
REQ-025 No request: mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
REQ-026 mem_wdata SHALL be 0 whenever the granted access is not a data write.
REQ-027 Streak counter (4 bits): +1 on each cycle dm_gnt=1 and if_req=1; cleared to 0 on any if_gnt or any cycle if_req=0; saturates at STARVE_LIMIT.
REQ-028 Read latency exactly 1 cycle: cycle after if_gnt, if_valid=1 and if_rdata=mem_rdata sampled at grant; same for dm_gnt with dm_wr=0 -> dm_valid/dm_rdata.
REQ-029 Data writes complete at the grant edge; no dm_valid for writes.
REQ-030 Valid pulses last one cycle; rdata registers hold last value when valid=0.
REQ-031 Back-to-back grants to same port every cycle SHALL be supported with no bubble.
REQ-032 Requester holds req/address until its gnt; arbiter needs no extra handshake state.
REQ-033 Request dropped before grant: no access, no valid, no state change except REQ-027 clear.

Reset
REQ-034 rst=1 at an edge: streak=0, if_valid=0, dm_valid=0, if_rdata=0, dm_rdata=0.
REQ-035 While rst=1: if_gnt=0, dm_gnt=0, mem_en=0, mem_wr=0 regardless of requests; no memory write occurs.
REQ-036 Reset asserted mid-access: pending valid pulse next cycle SHALL be suppressed (valid=0 after reset edge).
REQ-037 First grant possible in the first cycle with rst=0.

Verification
REQ-038 if_req=1, if_addr=0x0005, mem holds 0xA1B2 at 5 -> if_gnt same cycle; next cycle if_valid=1, if_rdata=0xA1B2.
REQ-039 dm_req=1, dm_wr=1, dm_addr=0x1FFF, dm_wdata=0xBEEF, then dm read 0x1FFF -> mem_wr=1 one cycle; read returns dm_valid=1, dm_rdata=0xBEEF.
REQ-040 if_req and dm_req (reads) held high 10 cycles, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I,D,D,D,D,I; never both grants.
REQ-041 if_req drops after 2 dm streak grants then re-asserts with dm_req -> counter cleared; 4 more dm grants before fetch.
REQ-042 rst=1 in cycle after if_gnt -> no if_valid pulse, all outputs 0; after rst=0 with if_req=1, if_gnt=1 immediately.
REQ-043 Alternating single requests each cycle (I,D,I,D) -> each valid exactly one cycle after its grant, correct data per port.

Source files
------------

// File: rtl/mem_arb.sv
// Arbiter sharing one single-port memory between an instruction-fetch port and a data port.
// Data accesses win by default; a streak counter bounds how long fetch can be starved.
module mem_arb #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [12:0] if_addr,
   output logic        if_gnt,
   output logic [15:0] if_rdata,
   output logic        if_valid,
   input  logic        dm_req,
   input  logic        dm_wr,
   input  logic [12:0] dm_addr,
   input  logic [15:0] dm_wdata,
   output logic        dm_gnt,
   output logic [15:0] dm_rdata,
   output logic        dm_valid,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [12:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]  streak_q, streak_d;
   logic        if_valid_q, if_valid_d;
   logic [15:0] if_rdata_q, if_rdata_d;
   logic        dm_valid_q, dm_valid_d;
   logic [15:0] dm_rdata_q, dm_rdata_d;
   logic        fetch_turn;
   logic        if_gnt_w, dm_gnt_w;

   // Grant decision: fetch only beats a competing data request once the streak hits the limit.
   always_comb begin
      fetch_turn = (streak_q == LIMIT);
      if_gnt_w   = 1'b0;
      dm_gnt_w   = 1'b0;
      if (!rst) begin
         if (if_req && (!dm_req || fetch_turn)) begin
            if_gnt_w = 1'b1;
         end else if (dm_req) begin
            dm_gnt_w = 1'b1;
         end
      end
   end

   always_comb begin
      mem_en    = if_gnt_w | dm_gnt_w;
      mem_wr    = dm_gnt_w & dm_wr;
      mem_addr  = 13'h0000;
      mem_wdata = 16'h0000;
      if (if_gnt_w) begin
         mem_addr = if_addr;
      end else if (dm_gnt_w) begin
         mem_addr = dm_addr;
         if (dm_wr) begin
            mem_wdata = dm_wdata;
         end
      end
   end

   always_comb begin
      streak_d = streak_q;
      if (if_gnt_w || !if_req) begin
         streak_d = 4'd0;
      end else if (dm_gnt_w && (streak_q < LIMIT)) begin
         streak_d = streak_q + 4'd1;
      end
      if_valid_d = if_gnt_w;
      if_rdata_d = if_gnt_w ? mem_rdata : if_rdata_q;
      dm_valid_d = dm_gnt_w & ~dm_wr;
      dm_rdata_d = (dm_gnt_w && !dm_wr) ? mem_rdata : dm_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         streak_q   <= 4'd0;
         if_valid_q <= 1'b0;
         if_rdata_q <= 16'h0000;
         dm_valid_q <= 1'b0;
         dm_rdata_q <= 16'h0000;
      end else begin
         streak_q   <= streak_d;
         if_valid_q <= if_valid_d;
         if_rdata_q <= if_rdata_d;
         dm_valid_q <= dm_valid_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   // A read granted just before reset is raised must not surface while reset is held.
   assign if_gnt   = if_gnt_w;
   assign dm_gnt   = dm_gnt_w;
   assign if_valid = if_valid_q & ~rst;
   assign if_rdata = rst ? 16'h0000 : if_rdata_q;
   assign dm_valid = dm_valid_q & ~rst;
   assign dm_rdata = rst ? 16'h0000 : dm_rdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed table-driven bench for mem_arb with a behavioural single-port memory.
module tb_mem_arb;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [12:0] if_addr;
   logic        if_gnt;
   logic [15:0] if_rdata;
   logic        if_valid;
   logic        dm_req;
   logic        dm_wr;
   logic [12:0] dm_addr;
   logic [15:0] dm_wdata;
   logic        dm_gnt;
   logic [15:0] dm_rdata;
   logic        dm_valid;
   logic        mem_en;
   logic        mem_wr;
   logic [12:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   int checks;
   int failures;
   logic mon_on;

   logic [15:0] mem [0:8191];

   mem_arb #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_en && mem_wr) mem[mem_addr] <= mem_wdata;
   end

   typedef struct packed {
      logic        rst;
      logic        ir;
      logic [12:0] ia;
      logic        dr;
      logic        dw;
      logic [12:0] da;
      logic [15:0] wd;
      logic        eig;
      logic        edg;
      logic        een;
      logic        ewr;
      logic [12:0] ema;
      logic [15:0] emwd;
      logic        eiv;
      logic [15:0] eird;
      logic        edv;
      logic [15:0] edrd;
   } vec_t;

   localparam int NV = 35;
   vec_t vecs [NV];

   function automatic vec_t mk(
      input logic rs, input logic ir, input logic [12:0] ia,
      input logic dr, input logic dw, input logic [12:0] da, input logic [15:0] wd,
      input logic eig, input logic edg, input logic een, input logic ewr,
      input logic [12:0] ema, input logic [15:0] emwd,
      input logic eiv, input logic [15:0] eird, input logic edv, input logic [15:0] edrd);
      vec_t v;
      v.rst = rs; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.wd = wd;
      v.eig = eig; v.edg = edg; v.een = een; v.ewr = ewr; v.ema = ema; v.emwd = emwd;
      v.eiv = eiv; v.eird = eird; v.edv = edv; v.edrd = edrd;
      return v;
   endfunction

   // driver tasks
   task automatic drive(input logic rs, input logic ir, input logic [12:0] ia,
                        input logic dr, input logic dw, input logic [12:0] da,
                        input logic [15:0] wd);
      rst = rs; if_req = ir; if_addr = ia;
      dm_req = dr; dm_wr = dw; dm_addr = da; dm_wdata = wd;
   endtask

   task automatic check(input string name, input int row, input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row%0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   // grants must never overlap
   always @(negedge clk) begin
      if (mon_on) begin
         checks++;
         if (if_gnt && dm_gnt) begin
            failures++;
            $display("FAIL both_gnt at %0t: got 1 expected 0", $time);
         end
      end
   end

   initial begin
      checks = 0;
      failures = 0;
      mon_on = 1'b0;
      for (int a = 0; a < 8192; a++) mem[a] = 16'h0000;
      mem[13'h0005] = 16'hA1B2;
      mem[13'h0010] = 16'h1111;
      mem[13'h0020] = 16'h2222;
      mem[13'h0030] = 16'h3333;
      mem[13'h0040] = 16'h4444;

      //            rst ir ia     dr dw da      wd       ig dg en wr ma      mwd      iv ird      dv drd
      vecs[0]  = mk(1, 1, 13'h5,  1, 1, 13'h10, 16'hFFFF, 0, 0, 0, 0, 13'h0,  16'h0,   0, 16'h0,    0, 16'h0);
      vecs[1]  = mk(0, 1, 13'h5,  0, 0, 13'h0,  16'h0,    1, 0, 1, 0, 13'h5,  16'h0,   0, 16'h0,    0, 16'h0);
      vecs[2]  = mk(0, 0, 13'h0,  0, 0, 13'h0,  16'h0,    0, 0, 0, 0, 13'h0,  16'h0,   1, 16'hA1B2, 0, 16'h0);
      vecs[3]  = mk(0, 0, 13'h0,  1, 1, 13'h1FFF,16'hBEEF,0, 1, 1, 1, 13'h1FFF,16'hBEEF,0, 16'hA1B2, 0, 16'h0);
      vecs[4]  = mk(0, 0, 13'h0,  1, 0, 13'h1FFF,16'h1234,0, 1, 1, 0, 13'h1FFF,16'h0,   0, 16'hA1B2, 0, 16'h0);
      vecs[5]  = mk(0, 0, 13'h0,  0, 0, 13'h0,  16'h0,    0, 0, 0, 0, 13'h0,  16'h0,   0, 16'hA1B2, 1, 16'hBEEF);
      vecs[6]  = mk(0, 1, 13'h10, 0, 0, 13'h0,  16'h0,    1, 0, 1, 0, 13'h10, 16'h0,   0, 16'hA1B2, 0, 16'hBEEF);
      vecs[7]  = mk(0, 0, 13'h0,  1, 0, 13'h20, 16'h0,    0, 1, 1, 0, 13'h20, 16'h0,   1, 16'h1111, 0, 16'hBEEF);
      vecs[8]  = mk(0, 1, 13'h30, 0, 0, 13'h0,  16'h0,    1, 0, 1, 0, 13'h30, 16'h0,   0, 16'h1111, 1, 16'h2222);
      vecs[9]  = mk(0, 0, 13'h0,  1, 0, 13'h40, 16'h0,    0, 1, 1, 0, 13'h40, 16'h0,   1, 16'h3333, 0, 16'h2222);
      vecs[10] = mk(0, 0, 13'h0,  0, 0, 13'h0,  16'h0,    0, 0, 0, 0, 13'h0,  16'h0,   0, 16'h3333, 1, 16'h4444);
      // both ports hammering: D,D,D,D,I,D,D,D,D,I
      vecs[11] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    0, 1, 1, 0, 13'h20, 16'h0,   0, 16'h3333, 0, 16'h4444);
      vecs[12] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    0, 1, 1, 0, 13'h20, 16'h0,   0, 16'h3333, 1, 16'h2222);
      vecs[13] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    0, 1, 1, 0, 13'h20, 16'h0,   0, 16'h3333, 1, 16'h2222);
      vecs[14] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    0, 1, 1, 0, 13'h20, 16'h0,   0, 16'h3333, 1, 16'h2222);
      vecs[15] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    1, 0, 1, 0, 13'h5,  16'h0,   0, 16'h3333, 1, 16'h2222);
      vecs[16] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    0, 1, 1, 0, 13'h20, 16'h0,   1, 16'hA1B2, 0, 16'h2222);
      vecs[17] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    0, 1, 1, 0, 13'h20, 16'h0,   0, 16'hA1B2, 1, 16'h2222);
      vecs[18] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    0, 1, 1, 0, 13'h20, 16'h0,   0, 16'hA1B2, 1, 16'h2222);
      vecs[19] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    0, 1, 1, 0, 13'h20, 16'h0,   0, 16'hA1B2, 1, 16'h2222);
      vecs[20] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    1, 0, 1, 0, 13'h5,  16'h0,   0, 16'hA1B2, 1, 16'h2222);
      // streak of 2, fetch drops (clears streak), then four full data grants before fetch
      vecs[21] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    0, 1, 1, 0, 13'h20, 16'h0,   1, 16'hA1B2, 0, 16'h2222);
      vecs[22] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    0, 1, 1, 0, 13'h20, 16'h0,   0, 16'hA1B2, 1, 16'h2222);
      vecs[23] = mk(0, 0, 13'h0,  1, 0, 13'h20, 16'h0,    0, 1, 1, 0, 13'h20, 16'h0,   0, 16'hA1B2, 1, 16'h2222);
      vecs[24] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    0, 1, 1, 0, 13'h20, 16'h0,   0, 16'hA1B2, 1, 16'h2222);
      vecs[25] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    0, 1, 1, 0, 13'h20, 16'h0,   0, 16'hA1B2, 1, 16'h2222);
      vecs[26] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    0, 1, 1, 0, 13'h20, 16'h0,   0, 16'hA1B2, 1, 16'h2222);
      vecs[27] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    0, 1, 1, 0, 13'h20, 16'h0,   0, 16'hA1B2, 1, 16'h2222);
      vecs[28] = mk(0, 1, 13'h5,  1, 0, 13'h20, 16'h0,    1, 0, 1, 0, 13'h5,  16'h0,   0, 16'hA1B2, 1, 16'h2222);
      vecs[29] = mk(0, 0, 13'h0,  0, 0, 13'h0,  16'h0,    0, 0, 0, 0, 13'h0,  16'h0,   1, 16'hA1B2, 0, 16'h2222);
      // reset right after a fetch grant, with a write pending that must not land
      vecs[30] = mk(0, 1, 13'h30, 0, 0, 13'h0,  16'h0,    1, 0, 1, 0, 13'h30, 16'h0,   0, 16'hA1B2, 0, 16'h2222);
      vecs[31] = mk(1, 1, 13'h30, 1, 1, 13'h40, 16'hDEAD, 0, 0, 0, 0, 13'h0,  16'h0,   0, 16'h0,    0, 16'h0);
      vecs[32] = mk(0, 1, 13'h10, 0, 0, 13'h0,  16'h0,    1, 0, 1, 0, 13'h10, 16'h0,   0, 16'h0,    0, 16'h0);
      vecs[33] = mk(0, 0, 13'h0,  1, 0, 13'h40, 16'h0,    0, 1, 1, 0, 13'h40, 16'h0,   1, 16'h1111, 0, 16'h0);
      vecs[34] = mk(0, 0, 13'h0,  0, 0, 13'h0,  16'h0,    0, 0, 0, 0, 13'h0,  16'h0,   0, 16'h1111, 1, 16'h4444);

      drive(1, 0, 13'h0, 0, 0, 13'h0, 16'h0);
      repeat (2) @(posedge clk);
      mon_on = 1'b1;

      for (int i = 0; i < NV; i++) begin
         #1;
         drive(vecs[i].rst, vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].wd);
         @(negedge clk);
         check("if_gnt",    i, {15'h0, if_gnt},   {15'h0, vecs[i].eig});
         check("dm_gnt",    i, {15'h0, dm_gnt},   {15'h0, vecs[i].edg});
         check("mem_en",    i, {15'h0, mem_en},   {15'h0, vecs[i].een});
         check("mem_wr",    i, {15'h0, mem_wr},   {15'h0, vecs[i].ewr});
         check("mem_addr",  i, {3'h0, mem_addr},  {3'h0, vecs[i].ema});
         check("mem_wdata", i, mem_wdata,         vecs[i].emwd);
         check("if_valid",  i, {15'h0, if_valid}, {15'h0, vecs[i].eiv});
         check("if_rdata",  i, if_rdata,          vecs[i].eird);
         check("dm_valid",  i, {15'h0, dm_valid}, {15'h0, vecs[i].edv});
         check("dm_rdata",  i, dm_rdata,          vecs[i].edrd);
         @(posedge clk);
      end

      // fetch request withdrawn before it was ever granted: no fetch access, no pulse
      #1;
      drive(0, 1, 13'h30, 1, 0, 13'h20, 16'h0);
      @(negedge clk);
      check("drop_if_gnt", 100, {15'h0, if_gnt}, 16'h0);
      check("drop_dm_gnt", 100, {15'h0, dm_gnt}, 16'h1);
      @(posedge clk);
      #1;
      drive(0, 0, 13'h0, 0, 0, 13'h0, 16'h0);
      @(negedge clk);
      check("drop_if_valid", 101, {15'h0, if_valid}, 16'h0);
      check("drop_dm_valid", 101, {15'h0, dm_valid}, 16'h1);
      check("drop_dm_rdata", 101, dm_rdata, 16'h2222);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("drop_if_valid2", 102, {15'h0, if_valid}, 16'h0);
      check("drop_if_rdata",  102, if_rdata, 16'h1111);
      check("drop_dm_valid2", 102, {15'h0, dm_valid}, 16'h0);
      check("mem_1fff",       102, mem[13'h1FFF], 16'hBEEF);
      check("mem_40_kept",    102, mem[13'h0040], 16'h4444);

      mon_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
